// File: rtl/ebpc_dispatch_gen2.sv
// EBPC front-end dispatcher: splits the activation stream into ZNZ flags and non-zero BPC words,
// zero-pads the final BPC block of each compressed stream, and offers a raw bypass path.
module ebpc_dispatch_gen2 #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BLOCK_SIZE = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic              idle_o,
  output logic [DATA_W-1:0] bpc_data_o,
  output logic              bpc_flush_o,
  output logic              bpc_vld_o,
  input  logic              bpc_rdy_i,
  input  logic              bpc_idle_i,
  output logic              znz_is_one_o,
  output logic              znz_flush_o,
  output logic              znz_vld_o,
  input  logic              znz_rdy_i,
  input  logic              znz_idle_i,
  output logic [DATA_W-1:0] byp_data_o,
  output logic              byp_last_o,
  output logic              byp_vld_o,
  input  logic              byp_rdy_i,
  output logic [CNT_W-1:0]  nz_cnt_o,
  output logic [CNT_W-1:0]  word_cnt_o
);

  localparam int unsigned BlkW = $clog2(BLOCK_SIZE);

  typedef enum logic [1:0] {StIdle, StRun, StPad} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                mode_q, mode_d;
  logic                pend_bpc_q, pend_bpc_d;
  logic                pend_znz_q, pend_znz_d;
  logic                pend_byp_q, pend_byp_d;
  logic [BlkW-1:0]     blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]    nz_cnt_q, nz_cnt_d;

  logic bpc_hs, znz_hs, byp_hs;
  logic any_pend, all_done, acc, eff_mode, data_nz, stream_end, in_pad;

  assign in_pad = (state_q == StPad);

  assign bpc_vld_o    = pend_bpc_q | in_pad;
  assign bpc_data_o   = in_pad ? '0 : data_q;
  assign bpc_flush_o  = in_pad | last_q;
  assign znz_vld_o    = pend_znz_q;
  assign znz_is_one_o = |data_q;
  assign znz_flush_o  = last_q;
  assign byp_vld_o    = pend_byp_q;
  assign byp_data_o   = data_q;
  assign byp_last_o   = last_q;
  assign nz_cnt_o     = nz_cnt_q;
  assign word_cnt_o   = word_cnt_q;

  assign bpc_hs   = bpc_vld_o & bpc_rdy_i;
  assign znz_hs   = znz_vld_o & znz_rdy_i;
  assign byp_hs   = byp_vld_o & byp_rdy_i;
  assign any_pend = pend_bpc_q | pend_znz_q | pend_byp_q;
  assign all_done = (~pend_bpc_q | bpc_hs) & (~pend_znz_q | znz_hs) & (~pend_byp_q | byp_hs);

  // A last word blocks intake in the cycle it drains, leaving one bubble between streams.
  assign rdy_o      = ~in_pad & (~any_pend | (all_done & ~last_q));
  assign acc        = vld_i & rdy_o;
  assign eff_mode   = (state_q == StIdle) ? mode_i : mode_q;
  assign data_nz    = |data_i;
  assign stream_end = any_pend & all_done & last_q;

  assign idle_o = (state_q == StIdle) & ~any_pend & bpc_idle_i & znz_idle_i;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    last_d     = last_q;
    mode_d     = mode_q;
    pend_bpc_d = pend_bpc_q & ~bpc_hs;
    pend_znz_d = pend_znz_q & ~znz_hs;
    pend_byp_d = pend_byp_q & ~byp_hs;
    blk_cnt_d  = blk_cnt_q + BlkW'(bpc_hs);
    word_cnt_d = word_cnt_q;
    nz_cnt_d   = nz_cnt_q;

    if (acc) begin
      data_d     = data_i;
      last_d     = last_i;
      pend_znz_d = ~eff_mode;
      pend_bpc_d = ~eff_mode & data_nz;
      pend_byp_d = eff_mode;
      if (state_q == StIdle) begin
        mode_d     = mode_i;
        word_cnt_d = CNT_W'(1);
        nz_cnt_d   = CNT_W'(data_nz);
      end else begin
        if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_W'(1);
        if (data_nz && nz_cnt_q != '1) nz_cnt_d = nz_cnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StIdle: if (acc) state_d = StRun;
      StRun: begin
        if (stream_end) begin
          state_d = (!mode_q && blk_cnt_d != '0) ? StPad : StIdle;
        end
      end
      StPad: if (bpc_hs && blk_cnt_q == BlkW'(BLOCK_SIZE - 1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      data_q     <= '0;
      last_q     <= 1'b0;
      mode_q     <= 1'b0;
      pend_bpc_q <= 1'b0;
      pend_znz_q <= 1'b0;
      pend_byp_q <= 1'b0;
      blk_cnt_q  <= '0;
      word_cnt_q <= '0;
      nz_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      last_q     <= last_d;
      mode_q     <= mode_d;
      pend_bpc_q <= pend_bpc_d;
      pend_znz_q <= pend_znz_d;
      pend_byp_q <= pend_byp_d;
      blk_cnt_q  <= blk_cnt_d;
      word_cnt_q <= word_cnt_d;
      nz_cnt_q   <= nz_cnt_d;
    end
  end

endmodule

// File: tb/tb_ebpc_dispatch_gen2.sv
// Randomised bench for ebpc_dispatch_gen2: per-stream reference model fills expected output
// queues, a per-cycle monitor matches every branch handshake against them.
module tb_ebpc_dispatch_gen2;

  localparam int unsigned DW = 8;
  localparam int unsigned BS = 8;
  localparam int unsigned CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef logic [DW-1:0] wq_t[$];
  typedef struct packed {logic [DW-1:0] d; logic f;} ent_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic mode_i, last_i, vld_i, rdy_o, idle_o;
  logic [DW-1:0] data_i, bpc_data_o, byp_data_o;
  logic bpc_flush_o, bpc_vld_o, bpc_rdy_i, bpc_idle_i;
  logic znz_is_one_o, znz_flush_o, znz_vld_o, znz_rdy_i, znz_idle_i;
  logic byp_last_o, byp_vld_o, byp_rdy_i;
  logic [CW-1:0] nz_cnt_o, word_cnt_o;

  ebpc_dispatch_gen2 #(.DATA_W(DW), .BLOCK_SIZE(BS), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .mode_i(mode_i), .data_i(data_i), .last_i(last_i),
    .vld_i(vld_i), .rdy_o(rdy_o), .idle_o(idle_o),
    .bpc_data_o(bpc_data_o), .bpc_flush_o(bpc_flush_o), .bpc_vld_o(bpc_vld_o),
    .bpc_rdy_i(bpc_rdy_i), .bpc_idle_i(bpc_idle_i),
    .znz_is_one_o(znz_is_one_o), .znz_flush_o(znz_flush_o), .znz_vld_o(znz_vld_o),
    .znz_rdy_i(znz_rdy_i), .znz_idle_i(znz_idle_i),
    .byp_data_o(byp_data_o), .byp_last_o(byp_last_o), .byp_vld_o(byp_vld_o),
    .byp_rdy_i(byp_rdy_i), .nz_cnt_o(nz_cnt_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  ent_t bpc_q[$], znz_q[$], byp_q[$];
  int   n_cmp = 0, n_err = 0;
  int   bp = 0;  // 0 all ready, 1 random, 2 manual
  logic m_bpc = 1'b1, m_znz = 1'b1, m_byp = 1'b1;
  logic accepted;
  int   exp_word = 0, exp_nz = 0, model_blk = 0;

  // One cycle: check branch outputs mid-cycle, then update ready inputs after the edge.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    accepted = vld_i && rdy_o;
    if (bpc_vld_o) begin
      if (bpc_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL bpc_unexpected: got data=%h flush=%b, required no bpc_vld", bpc_data_o, bpc_flush_o);
      end else if (bpc_rdy_i) begin
        e = bpc_q.pop_front(); n_cmp++;
        if ({bpc_data_o, bpc_flush_o} !== {e.d, e.f}) begin
          n_err++;
          $display("FAIL bpc_word: got %h/%b required %h/%b", bpc_data_o, bpc_flush_o, e.d, e.f);
        end
      end
    end
    if (znz_vld_o) begin
      if (znz_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL znz_unexpected: got is_one=%b flush=%b, required no znz_vld", znz_is_one_o, znz_flush_o);
      end else if (znz_rdy_i) begin
        e = znz_q.pop_front(); n_cmp++;
        if ({znz_is_one_o, znz_flush_o} !== {e.d[0], e.f}) begin
          n_err++;
          $display("FAIL znz_word: got %b/%b required %b/%b", znz_is_one_o, znz_flush_o, e.d[0], e.f);
        end
      end
    end
    if (byp_vld_o) begin
      if (byp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL byp_unexpected: got data=%h last=%b, required no byp_vld", byp_data_o, byp_last_o);
      end else if (byp_rdy_i) begin
        e = byp_q.pop_front(); n_cmp++;
        if ({byp_data_o, byp_last_o} !== {e.d, e.f}) begin
          n_err++;
          $display("FAIL byp_word: got %h/%b required %h/%b", byp_data_o, byp_last_o, e.d, e.f);
        end
      end
    end
    @(posedge clk); #1;
    case (bp)
      0: begin bpc_rdy_i = 1'b1; znz_rdy_i = 1'b1; byp_rdy_i = 1'b1; end
      1: begin
        bpc_rdy_i = ($urandom_range(0, 3) != 0);
        znz_rdy_i = ($urandom_range(0, 3) != 0);
        byp_rdy_i = ($urandom_range(0, 3) != 0);
      end
      default: begin bpc_rdy_i = m_bpc; znz_rdy_i = m_znz; byp_rdy_i = m_byp; end
    endcase
  endtask

  // Expected branch traffic of one whole stream, derived from the word list alone.
  task automatic model_stream(input wq_t w, input logic md);
    ent_t e;
    int nz = 0;
    for (int i = 0; i < w.size(); i++) begin
      logic lst = (i == w.size() - 1);
      if (w[i] != 0) nz++;
      if (md) begin
        e.d = w[i]; e.f = lst; byp_q.push_back(e);
      end else begin
        e.d = DW'(w[i] != 0); e.f = lst; znz_q.push_back(e);
        if (w[i] != 0) begin e.d = w[i]; e.f = lst; bpc_q.push_back(e); end
      end
    end
    if (!md) begin
      model_blk = (model_blk + nz) % BS;
      if (model_blk != 0)
        for (int k = 0; k < BS - model_blk; k++) begin e.d = '0; e.f = 1'b1; bpc_q.push_back(e); end
      model_blk = 0;
    end
    exp_word = (w.size() > CMAX) ? CMAX : w.size();
    exp_nz   = (nz > CMAX) ? CMAX : nz;
  endtask

  task automatic drive_stream(input wq_t w, input logic md, output int cycles);
    int guard;
    cycles = 0;
    for (int i = 0; i < w.size(); i++) begin
      vld_i = 1'b1; data_i = w[i]; last_i = (i == w.size() - 1);
      mode_i = (i == 0) ? md : ~md;
      guard = 0;
      do begin tick(); cycles++; guard++; end while (!accepted && guard < 200);
      if (!accepted) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: word %0d not accepted, required acceptance within 200 cycles", i);
        break;
      end
    end
    vld_i = 1'b0; last_i = 1'b0; mode_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (!idle_o && guard < 300) begin tick(); guard++; end
    n_cmp++;
    if (!idle_o) begin n_err++; $display("FAIL %s_idle: got idle_o=0 required 1", name); end
    n_cmp++;
    if (bpc_q.size() + znz_q.size() + byp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing: got %0d/%0d/%0d outstanding bpc/znz/byp words required 0/0/0",
               name, bpc_q.size(), znz_q.size(), byp_q.size());
    end
    n_cmp++;
    if (word_cnt_o !== CW'(exp_word) || nz_cnt_o !== CW'(exp_nz)) begin
      n_err++;
      $display("FAIL %s_counts: got word=%0d nz=%0d required word=%0d nz=%0d",
               name, word_cnt_o, nz_cnt_o, exp_word, exp_nz);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    n_cmp++;
    if ({rdy_o, bpc_vld_o, znz_vld_o, byp_vld_o, idle_o} !== 5'b10001) begin
      n_err++; $display("FAIL reset_flags: got rdy,vld*3,idle=%b required 10001",
                        {rdy_o, bpc_vld_o, znz_vld_o, byp_vld_o, idle_o});
    end
    n_cmp++;
    if (word_cnt_o !== '0 || nz_cnt_o !== '0) begin
      n_err++; $display("FAIL reset_counts: got %0d/%0d required 0/0", word_cnt_o, nz_cnt_o);
    end
    bpc_idle_i = 1'b0; #1;
    n_cmp++;
    if (idle_o !== 1'b0) begin n_err++; $display("FAIL idle_gating: got idle_o=%b required 0", idle_o); end
    bpc_idle_i = 1'b1;
  endtask

  task automatic test_compress_basic();
    wq_t w = '{8'h05, 8'h00, 8'h03};
    int c;
    bp = 0;
    model_stream(w, 1'b0);
    drive_stream(w, 1'b0, c);
    drain("compress_basic");
  endtask

  task automatic test_split_bp();
    wq_t w = '{8'hA5, 8'h00};
    wq_t w2 = '{8'h00};
    int c;
    bp = 2; m_bpc = 1'b0; m_znz = 1'b1; m_byp = 1'b1;
    bpc_rdy_i = 1'b0; znz_rdy_i = 1'b1; byp_rdy_i = 1'b1;
    model_stream(w, 1'b0);
    vld_i = 1'b1; data_i = 8'hA5; last_i = 1'b0; mode_i = 1'b0;
    tick();
    vld_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin m_bpc = 1'b1; bpc_rdy_i = 1'b1; #1; end
      n_cmp++;
      if ({bpc_vld_o, bpc_data_o, rdy_o, znz_vld_o} !== {1'b1, 8'hA5, (k == 3), (k == 0)}) begin
        n_err++;
        $display("FAIL split_hold%0d: got bpc_vld=%b data=%h rdy=%b znz_vld=%b required 1/a5/%b/%b",
                 k, bpc_vld_o, bpc_data_o, rdy_o, znz_vld_o, (k == 3), (k == 0));
      end
      tick();
    end
    n_cmp++;
    if (bpc_vld_o !== 1'b0) begin n_err++; $display("FAIL split_release: got bpc_vld=%b required 0", bpc_vld_o); end
    bp = 0;
    drive_stream(w2, 1'b0, c);
    drain("split_bp");
  endtask

  task automatic test_full_block();
    wq_t w;
    int c;
    bp = 0;
    for (int i = 0; i < BS; i++) w.push_back(DW'($urandom_range(1, 255)));
    model_stream(w, 1'b0);
    drive_stream(w, 1'b0, c);
    tick();
    n_cmp++;
    if ({rdy_o, bpc_vld_o, idle_o} !== 3'b101) begin
      n_err++; $display("FAIL full_block_nopad: got rdy,bpc_vld,idle=%b required 101",
                        {rdy_o, bpc_vld_o, idle_o});
    end
    drain("full_block");
  endtask

  task automatic test_bypass();
    wq_t w = '{8'h00, 8'h7F};
    int c;
    bp = 0;
    model_stream(w, 1'b1);
    drive_stream(w, 1'b1, c);
    drain("bypass");
  endtask

  task automatic test_back_to_back();
    wq_t w;
    bp = 0;
    for (int i = 0; i < 16; i++) w.push_back(($urandom_range(0, 2) == 0) ? 8'h00 : DW'($urandom));
    model_stream(w, 1'b0);
    for (int i = 0; i < 16; i++) begin
      vld_i = 1'b1; data_i = w[i]; last_i = (i == 15); mode_i = 1'b0;
      tick();
      n_cmp++;
      if (!accepted || znz_vld_o !== 1'b1 || znz_is_one_o !== (w[i] != 0)) begin
        n_err++;
        $display("FAIL b2b_word%0d: got accepted=%b znz_vld=%b is_one=%b required 1/1/%b",
                 i, accepted, znz_vld_o, znz_is_one_o, (w[i] != 0));
      end
    end
    vld_i = 1'b0; last_i = 1'b0;
    drain("back_to_back");
  endtask

  task automatic test_reset_in_pad();
    wq_t w = '{8'h11, 8'h22, 8'h33};
    wq_t w2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int c;
    bp = 0;
    model_stream(w, 1'b0);
    drive_stream(w, 1'b0, c);
    tick();
    bp = 2; m_bpc = 1'b0; bpc_rdy_i = 1'b0; #1;
    n_cmp++;
    if ({bpc_vld_o, bpc_data_o, bpc_flush_o, rdy_o} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL pad_state: got vld=%b data=%h flush=%b rdy=%b required 1/00/1/0",
                        bpc_vld_o, bpc_data_o, bpc_flush_o, rdy_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({bpc_vld_o, znz_vld_o, byp_vld_o, rdy_o} !== 4'b0001) begin
      n_err++; $display("FAIL reset_in_pad: got vld*3,rdy=%b required 0001",
                        {bpc_vld_o, znz_vld_o, byp_vld_o, rdy_o});
    end
    bpc_q.delete(); znz_q.delete(); byp_q.delete();
    model_blk = 0; exp_word = 0; exp_nz = 0;
    @(posedge clk); #3 rst_ni = 1'b1;
    bp = 0; m_bpc = 1'b1;
    tick();
    n_cmp++;
    if (rdy_o !== 1'b1 || word_cnt_o !== '0) begin
      n_err++; $display("FAIL post_reset: got rdy=%b word=%0d required 1/0", rdy_o, word_cnt_o);
    end
    model_stream(w2, 1'b0);
    drive_stream(w2, 1'b0, c);
    drain("after_pad_reset");
  endtask

  task automatic test_random();
    for (int s = 0; s < 12; s++) begin
      wq_t w;
      logic md = $urandom_range(0, 1);
      int len = $urandom_range(1, 20);
      int c;
      for (int i = 0; i < len; i++) w.push_back(($urandom_range(0, 2) == 0) ? 8'h00 : DW'($urandom));
      bp = 1;
      model_stream(w, md);
      drive_stream(w, md, c);
      drain($sformatf("random%0d", s));
    end
  endtask

  initial begin
    mode_i = 1'b0; data_i = '0; last_i = 1'b0; vld_i = 1'b0;
    bpc_rdy_i = 1'b1; znz_rdy_i = 1'b1; byp_rdy_i = 1'b1;
    bpc_idle_i = 1'b1; znz_idle_i = 1'b1;
    test_reset();
    test_compress_basic();
    test_split_bp();
    test_full_block();
    test_bypass();
    test_back_to_back();
    test_reset_in_pad();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ebpc_dispatch_gen2.md
Name: ebpc_dispatch_gen2

Overview:
- Parametrised front-end of the EBPC compressor. Sits between the activation stream and the BPC and zero/non-zero (ZNZ) run-length sub-encoders.
- Per word: issues a non-zero flag to the ZNZ branch and non-zero words to the BPC branch, and pads each stream's last BPC block with zero words.
- New over the previous generation: width and block size are parameters, there is a raw-bypass mode, per-branch pending flags replace the single wait state, and per-stream statistics counters are provided.

Parameters:
DATA_W, 8, word width in bits, >=2
BLOCK_SIZE, 8, BPC block length in words, power of 2, >=2
CNT_W, 16, width of the statistics counters

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mode_i  in  1  0=compress, 1=bypass; sampled on first word of a stream
data_i  in  DATA_W  input word
last_i  in  1  marks last word of stream
vld_i  in  1  input valid
rdy_o  out  1  input ready
idle_o  out  1  block and both sub-encoders idle
bpc_data_o  out  DATA_W  word to BPC encoder
bpc_flush_o  out  1  flush qualifier to BPC encoder
bpc_vld_o  out  1  BPC valid
bpc_rdy_i  in  1  BPC ready
bpc_idle_i  in  1  BPC encoder idle
znz_is_one_o  out  1  1 = word is non-zero
znz_flush_o  out  1  flush qualifier to ZNZ encoder
znz_vld_o  out  1  ZNZ valid
znz_rdy_i  in  1  ZNZ ready
znz_idle_i  in  1  ZNZ encoder idle
byp_data_o  out  DATA_W  bypass word
byp_last_o  out  1  bypass last
byp_vld_o  out  1  bypass valid
byp_rdy_i  in  1  bypass ready
nz_cnt_o  out  CNT_W  non-zero words in current/last stream
word_cnt_o  out  CNT_W  words in current/last stream

Behaviour:
- Registers: data_q, last_q, mode_q, pend_bpc, pend_znz, pend_byp, blk_cnt ($clog2(BLOCK_SIZE) bits), counters.
- FSM states: S_IDLE (no stream open), S_RUN, S_PAD.
- Reset: S_IDLE; all registers 0; all *_vld_o 0; rdy_o 1; counters 0.
- Accepting a word (vld_i && rdy_o):
  - Loads data_q and last_q.
  - Compress: sets pend_znz=1 and pend_bpc=(data_i!=0).
  - Bypass: sets pend_byp=1.
  - In S_IDLE: also loads mode_q=mode_i, clears both counters, moves to S_RUN. mode_i is ignored mid-stream.
- Latency: 1 cycle from acceptance to the *_vld_o outputs.
- Branch outputs:
  - bpc_vld_o=pend_bpc, znz_vld_o=pend_znz, byp_vld_o=pend_byp.
  - bpc_data_o=data_q (0 in S_PAD); byp_data_o=data_q.
  - znz_is_one_o=(data_q!=0); znz_flush_o=last_q; bpc_flush_o=last_q (1 in S_PAD); byp_last_o=last_q.
  - Each pend flag clears on its own handshake and is never re-asserted for the same word, so there is no duplicate issue under split backpressure. Data is held stable while any flag is set.
- rdy_o=1 when:
  - no pend flag is set and state!=S_PAD, or
  - all set flags complete this cycle and last_q=0.
  - This gives 1 word/cycle at full throughput.
- Last word: rdy_o stays 0 in the cycle its flags clear. Next state is S_PAD if compress and the next blk_cnt!=0, else S_IDLE. This inserts one bubble between streams.
- blk_cnt: increments on every BPC handshake (real or pad) and wraps BLOCK_SIZE-1 -> 0.
- S_PAD: bpc_vld_o=1 with zero data; each handshake increments blk_cnt. Exit to S_IDLE on the handshake that wraps blk_cnt to 0. rdy_o=0.
- Counters:
  - word_cnt increments on each accepted word.
  - nz_cnt increments on each accepted non-zero word, in both modes.
  - Both saturate at 2^CNT_W-1. Pad words are not counted.
  - Values hold after the stream ends until the next stream's first word.
- idle_o = S_IDLE && no pend flag && bpc_idle_i && znz_idle_i.
- blk_cnt persists in bypass mode (unchanged) so compress blocks stay aligned only within one stream. It is 0 at every compress stream end.
- Reset mid-operation (including S_PAD): all state clears immediately and asynchronously. Outstanding words and padding are dropped.

Test Plan:
- Compress, DATA_W=8, BLOCK_SIZE=8, all rdy=1, input 0x05,0x00,0x03(last):
  - ZNZ is_one 1,0,1 with flush on the 3rd.
  - BPC gets 0x05,0x03, then 6 zero words with flush=1.
  - blk_cnt returns to 0; nz_cnt=2, word_cnt=3; idle_o=1 afterwards.
- Split backpressure: word 0xA5, znz_rdy_i=1, bpc_rdy_i=0 for 3 cycles:
  - Exactly one ZNZ handshake.
  - bpc_vld_o held with 0xA5 for 4 cycles; rdy_o=0 until the BPC handshake.
- 8 non-zero words, last on the 8th:
  - No padding (S_PAD never entered); S_IDLE on the next cycle; nz_cnt=8.
- Bypass, mode_i=1 on the first word; input 0x00,0x7F(last) with mode_i toggled to 0 on the 2nd word:
  - byp_vld_o for both words, byp_last_o on 0x7F.
  - bpc_vld_o and znz_vld_o never asserted; word_cnt=2, nz_cnt=1.
- Throughput: 16 back-to-back compress words, all rdy=1:
  - rdy_o continuously 1; one ZNZ handshake per cycle.
  - Output order matches input; 1-cycle latency.
- Reset asserted during S_PAD with blk_cnt=3:
  - All *_vld_o drop to 0 immediately; after release rdy_o=1, blk_cnt=0.
  - A new stream encodes correctly.
